// File: rtl/fsm_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fsm_seq_ctrl_if
// Bundles the control/feedback signals between the board-level controller,
// the route sequencer and the six-state switch FSM.
//
//   start     : request a run. It is a level, not a pulse handshake: it is only
//               looked at while the sequencer is idle or in error (busy==0).
//               While busy==1 it is ignored. Completion is reported by a
//               single-cycle done pulse; failure by the sticky err flag.
//   abort     : cancel a run in progress (only effective while busy==1)
//   route_sel : route number, captured when start is accepted
//   led_in    : state code reported back by the switch FSM
//   sw_out    : registered switch code driven into the switch FSM
//   busy      : run in progress (driving or holding a step)
//   done      : one-cycle pulse after the last step has been confirmed
//   err       : sticky failure flag (timeout or rejected start)
//   step_idx  : current step number inside the route, 0-based
//   state_dbg : raw sequencer state, for observation only
// ---------------------------------------------------------------------------
interface fsm_seq_ctrl_if;
   logic       start;
   logic       abort;
   logic [1:0] route_sel;
   logic [2:0] led_in;
   logic [2:0] sw_out;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] step_idx;
   logic [2:0] state_dbg;

   modport master (
      output start, abort, route_sel, led_in,
      input  sw_out, busy, done, err, step_idx, state_dbg
   );

   modport slave (
      input  start, abort, route_sel, led_in,
      output sw_out, busy, done, err, step_idx, state_dbg
   );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_seq_ctrl
// Plays a pre-programmed route of switch codes into the six-state switch FSM,
// confirms every step through the FSM's led feedback, and flags a timeout if
// the FSM does not reach the expected state in time.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low reset
//   bus    : fsm_seq_ctrl_if.slave (start/abort/route_sel/led_in in,
//            sw_out/busy/done/err/step_idx/state_dbg out)
//
// Routes (switch code -> expected led):
//   0 : 001->001, 010->010, 011->011, 100->100, 101->111, 110->000
//   1 : 100->100, 101->111, 110->000
//   2 : 001->001, 100->100, 101->111, 110->000
//   3 : illegal, rejected at start
// ---------------------------------------------------------------------------
module fsm_seq_ctrl #(
   parameter int TIMEOUT_CYC = 16,
   parameter int HOLD_CYC    = 4
) (
   input  logic          clk,
   input  logic          reset,
   fsm_seq_ctrl_if.slave bus
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_HOLD  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t        r_state, w_next;
   logic [1:0]    r_route, w_route_nxt;
   logic [2:0]    r_step, w_step_nxt;
   logic [2:0]    r_sw, w_sw_nxt;
   logic          r_err, w_err_nxt;
   logic [TW-1:0] r_to_cnt;
   logic [HW-1:0] r_hold_cnt;
   logic          w_start_ok;
   logic          w_match;
   logic          w_last;

   // Switch code of a given step of a route.
   function automatic logic [2:0] f_code(input logic [1:0] route, input logic [2:0] step);
      logic [2:0] code;
      code = 3'b000;
      case (route)
         2'd0:    code = step + 3'd1;                               // 001..110
         2'd1:    code = step + 3'd4;                               // 100..110
         2'd2:    code = (step == 3'd0) ? 3'b001 : step + 3'd3;     // 001,100..110
         default: code = 3'b000;
      endcase
      return code;
   endfunction

   // Led code the switch FSM shows after accepting a switch code.
   // S5 is encoded 111, and 110 sends the FSM home to IDLE (000).
   function automatic logic [2:0] f_exp(input logic [2:0] code);
      logic [2:0] led;
      case (code)
         3'b101:  led = 3'b111;
         3'b110:  led = 3'b000;
         default: led = code;
      endcase
      return led;
   endfunction

   function automatic logic [2:0] f_last(input logic [1:0] route);
      logic [2:0] last;
      case (route)
         2'd0:    last = 3'd5;
         2'd1:    last = 3'd2;
         2'd2:    last = 3'd3;
         default: last = 3'd0;
      endcase
      return last;
   endfunction

   // A run may only begin with a legal route and the switch FSM sitting in IDLE.
   assign w_start_ok = (bus.route_sel != 2'd3) && (bus.led_in == 3'b000);
   assign w_match    = (bus.led_in == f_exp(f_code(r_route, r_step)));
   assign w_last     = (r_step == f_last(r_route));

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_route    <= 2'd0;
         r_step     <= 3'd0;
         r_sw       <= 3'b000;
         r_err      <= 1'b0;
         r_to_cnt   <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_route    <= w_route_nxt;
         r_step     <= w_step_nxt;
         r_sw       <= w_sw_nxt;
         r_err      <= w_err_nxt;
         // Both counters run only in their own state, so they are already zero
         // on every entry into DRIVE or HOLD.
         r_to_cnt   <= (r_state == S_DRIVE) ? r_to_cnt + 1'b1 : '0;
         r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next      = r_state;
      w_route_nxt = r_route;
      w_step_nxt  = r_step;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE, S_ERR: begin
            if (bus.start) begin
               if (w_start_ok) begin
                  w_next      = S_DRIVE;
                  w_route_nxt = bus.route_sel;
                  w_step_nxt  = 3'd0;
                  w_err_nxt   = 1'b0;
               end else begin
                  w_next    = S_ERR;
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_DRIVE: begin
            // Abort beats a match, and a match beats the timeout.
            if (bus.abort) begin
               w_next = S_IDLE;
            end else if (w_match) begin
               w_next = S_HOLD;
            end else if (r_to_cnt == TO_LAST) begin
               w_next    = S_ERR;
               w_err_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.abort) begin
               w_next = S_IDLE;
            end else if (r_hold_cnt == HOLD_LAST) begin
               if (w_last) begin
                  w_next = S_DONE;
               end else begin
                  w_next     = S_DRIVE;
                  w_step_nxt = r_step + 3'd1;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // sw_out is registered from the upcoming state so the code is already
      // on the pins during the first DRIVE cycle.
      w_sw_nxt = (w_next == S_DRIVE) ? f_code(w_route_nxt, w_step_nxt) : 3'b000;
   end

   // Output logic.
   always_comb begin
      bus.sw_out    = r_sw;
      bus.busy      = (r_state == S_DRIVE) || (r_state == S_HOLD);
      bus.done      = (r_state == S_DONE);
      bus.err       = r_err;
      bus.step_idx  = r_step;
      bus.state_dbg = r_state;
   end

endmodule
